// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder datapath.
package serial_adder_pkg;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_PAD   = 1;

    function automatic int unsigned frame_len(input int unsigned width, input int unsigned pad);
        return width + pad;
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in, serial-out operand transmitter: LSB-first word followed by PAD zero bits,
// with a valid/ready load handshake and gapless reload on the final beat.
module piso_shifter
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned PAD   = DEF_PAD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             adv,
    output logic             serial_valid,
    output logic             serial_out,
    output logic             last,
    output logic             busy
);

    localparam int unsigned FRAME = frame_len(WIDTH, PAD);
    localparam int unsigned CW    = $clog2(FRAME + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);
    localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;

    logic w_shift;
    logic w_last;
    logic w_load;

    assign w_shift = (r_state == SHIFT);
    assign w_last  = w_shift && (r_cnt == LAST_CNT);
    assign w_load  = load_valid && load_ready;

    // A word is only taken when idle or on the consumed final beat (gapless reload).
    assign load_ready = !rst && ((r_state == IDLE) || (w_last && adv));

    assign serial_valid = w_shift;
    assign busy         = w_shift;
    assign last         = w_last;
    assign serial_out   = (w_shift && (r_cnt < DATA_CNT)) ? r_shreg[0] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_state <= SHIFT;
            r_shreg <= data_in;
            r_cnt   <= '0;
        end else if (w_shift && adv) begin
            if (w_last) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_shreg <= r_shreg >> 1;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed self-checking bench for piso_shifter (PAD=1 main instance, PAD=0 side instance).
module tb_piso_shifter;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] data_in;
    logic       adv;
    logic       serial_valid;
    logic       serial_out;
    logic       last;
    logic       busy;

    logic       load_valid1;
    logic       load_ready1;
    logic       adv1;
    logic       serial_valid1;
    logic       serial_out1;
    logic       last1;
    logic       busy1;

    logic [8:0] cap;
    logic [7:0] cap1;
    int         beats1;
    logic       clr1;

    int n_vec;
    int n_err;

    piso_shifter #(.WIDTH(8), .PAD(1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .data_in      (data_in),
        .adv          (adv),
        .serial_valid (serial_valid),
        .serial_out   (serial_out),
        .last         (last),
        .busy         (busy)
    );

    piso_shifter #(.WIDTH(8), .PAD(0)) u_dut_nopad (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid1),
        .load_ready   (load_ready1),
        .data_in      (data_in),
        .adv          (adv1),
        .serial_valid (serial_valid1),
        .serial_out   (serial_out1),
        .last         (last1),
        .busy         (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial capture stages: shift in at the MSB so the first bit ends up at bit 0.
    always_ff @(posedge clk) begin
        if (serial_valid && adv) cap <= {serial_out, cap[8:1]};
        if (clr1) begin
            beats1 <= 0;
        end else if (serial_valid1 && adv1) begin
            cap1   <= {serial_out1, cap1[7:1]};
            beats1 <= beats1 + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Load d, then check all 9 beats; stall_n idle cycles are inserted at beat stall_beat.
    task automatic run_frame(input logic [7:0] d, input int stall_beat, input int stall_n);
        int n;
        load_valid = 1'b1;
        data_in    = d;
        #1;
        chk("load_ready_idle", int'(load_ready), 1);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n = (i == stall_beat) ? stall_n : 0;
            for (int k = 0; k <= n; k++) begin
                adv = (k == n);
                #1;
                chk("valid", int'(serial_valid), 1);
                chk("bit", int'(serial_out), (i < 8) ? int'(d[i]) : 0);
                chk("last", int'(last), (i == 8) ? 1 : 0);
                chk("busy", int'(busy), 1);
                tick();
            end
        end
        adv = 1'b0;
        #1;
        chk("valid_after", int'(serial_valid), 0);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] ff;
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        load_valid  = 1'b0;
        load_valid1 = 1'b0;
        data_in     = 8'h00;
        adv         = 1'b0;
        adv1        = 1'b0;
        clr1        = 1'b1;
        a5          = 8'hA5;
        ff          = 8'hFF;

        // Reset state, with load_valid offered during reset.
        load_valid = 1'b1;
        data_in    = 8'h5A;
        tick();
        tick();
        chk("rst_valid", int'(serial_valid), 0);
        chk("rst_out", int'(serial_out), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(load_ready), 0);
        load_valid = 1'b0;
        rst        = 1'b0;
        clr1       = 1'b0;
        #1;
        chk("ready_after_rst", int'(load_ready), 1);
        tick();
        chk("idle_no_frame", int'(serial_valid), 0);

        // Basic frame, then loopback capture of the 9-bit frame.
        run_frame(8'hA5, -1, 0);
        chk("capture", int'(cap), 9'h0A5);

        // Stall three cycles on bit 2.
        run_frame(8'h3C, 2, 3);

        // Back-to-back frames: offer held, second word presented at the final beat.
        load_valid = 1'b1;
        data_in    = a5;
        tick();
        adv = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 8) data_in = ff;
            if (i == 9) load_valid = 1'b0;
            #1;
            chk("b2b_valid", int'(serial_valid), 1);
            if (i < 9) begin
                chk("b2b_ready", int'(load_ready), (i == 8) ? 1 : 0);
                chk("b2b_bit0", int'(serial_out), (i < 8) ? int'(a5[i]) : 0);
            end else begin
                chk("b2b_bit1", int'(serial_out), (i < 17) ? int'(ff[i - 9]) : 0);
            end
            tick();
        end
        adv = 1'b0;
        #1;
        chk("b2b_end", int'(serial_valid), 0);

        // Ignored load at cnt=4.
        load_valid = 1'b1;
        data_in    = a5;
        tick();
        load_valid = 1'b0;
        adv        = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                load_valid = 1'b1;
                data_in    = 8'h00;
                #1;
                chk("ign_ready", int'(load_ready), 0);
            end else begin
                load_valid = 1'b0;
            end
            #1;
            chk("ign_bit", int'(serial_out), (i < 8) ? int'(a5[i]) : 0);
            tick();
        end
        adv = 1'b0;
        #1;
        chk("ign_end", int'(serial_valid), 0);

        // Reset at cnt=5, then a fresh load.
        load_valid = 1'b1;
        data_in    = a5;
        tick();
        load_valid = 1'b0;
        adv        = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", int'(serial_valid), 0);
        chk("mid_rst_out", int'(serial_out), 0);
        chk("mid_rst_ready", int'(load_ready), 0);
        rst = 1'b0;
        adv = 1'b0;
        #1;
        chk("mid_rst_ready_rel", int'(load_ready), 1);
        tick();
        chk("mid_rst_stays_idle", int'(serial_valid), 0);
        run_frame(8'h81, -1, 0);

        // PAD=0: exactly eight beats, last on bit 7.
        clr1 = 1'b1;
        tick();
        clr1        = 1'b0;
        load_valid1 = 1'b1;
        data_in     = a5;
        tick();
        load_valid1 = 1'b0;
        adv1        = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("np_valid", int'(serial_valid1), 1);
            chk("np_bit", int'(serial_out1), int'(a5[i]));
            chk("np_last", int'(last1), (i == 7) ? 1 : 0);
            tick();
        end
        adv1 = 1'b0;
        chk("np_end", int'(serial_valid1), 0);
        chk("np_beats", beats1, 8);
        chk("np_capture", int'(cap1), 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
- Parallel-in, serial-out transmitter that feeds operands into the serial adder datapath. It is the transmit-side counterpart of the serial-to-parallel result capture.
- Accepts a WIDTH-bit word through a valid/ready load handshake. Shifts it out LSB-first, one bit per advance, then appends PAD zero bits so the adder can flush its carry.
- Two instances, one per operand, sit in front of the full-adder cell.

Parameters:
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- PAD, 1, zero bits appended after the operand; legal range 0..4. Total frame length is WIDTH+PAD bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  upstream offers data_in.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  parallel operand; sampled only on a load handshake.
- adv  input  1  downstream consumes the current bit this cycle (stall when low).
- serial_valid  output  1  serial_out holds a valid frame bit.
- serial_out  output  1  current bit, LSB first.
- last  output  1  high while the final bit of the frame (bit WIDTH+PAD-1) is presented.
- busy  output  1  frame in progress; equals serial_valid.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- State machine, `state_t` with states IDLE and SHIFT.
- Registers:
  - shreg: WIDTH bits.
  - cnt: $clog2(WIDTH+PAD+1) bits.
  - state.
- Reset values (on any rising clk edge with rst=1): state=IDLE, shreg=0, cnt=0, serial_valid=0, serial_out=0, last=0, busy=0.
- load_ready is combinational:
  - high when state=IDLE, or when state=SHIFT and last=1 and adv=1;
  - forced low while rst=1.
- Load:
  - Occurs when load_valid & load_ready at a clock edge: shreg<=data_in, cnt<=0, state<=SHIFT.
  - serial_valid rises the cycle after acceptance, presenting data_in[0]. Load-to-first-bit latency is 1 cycle.
- serial_out source:
  - shreg[0] while cnt<WIDTH;
  - 0 while WIDTH ≤ cnt < WIDTH+PAD.
- last = (state=SHIFT) & (cnt=WIDTH+PAD-1).
- Advance (state=SHIFT & adv=1, not last):
  - shreg<=shreg>>1 with zero fill; cnt<=cnt+1.
  - When adv=0, shreg and cnt hold and serial_out stays stable (stall of any length).
- Final advance (last & adv):
  - If load_valid=1: reload immediately, with the same assignments as a load. There is no idle bubble; back-to-back frames are contiguous.
  - Otherwise: state<=IDLE, serial_valid drops next cycle, cnt<=0.
- In SHIFT with last=0, load_valid is ignored. data_in is not sampled, and upstream must hold its offer.
- In IDLE, adv is ignored and serial_out=0.
- Reset mid-frame: abort on that edge. No further bits are emitted, and the next frame starts with a fresh load.
- Simultaneous rst and load_valid: reset wins; the word is not accepted.
- PAD=0: last coincides with bit WIDTH-1; no zero tail.
- Total bits per frame is exactly WIDTH+PAD. The count never wraps, because cnt is reset on every load and every return to IDLE.

Decomposition:
- Package `serial_adder_pkg`:
  - `state_t` enum {IDLE, SHIFT};
  - localparam `DEF_WIDTH` = 8;
  - localparam `DEF_PAD` = 1;
  - function `frame_len(width, pad)` returning width+pad.
- Implement as a single module. Counter and shifter are small enough that a sub-module adds nothing.

Test Plan:
- Basic frame (WIDTH=8, PAD=1):
  - Stimulus: load 8'hA5, adv held at 1.
  - Response: serial_out sequence 1,0,1,0,0,1,0,1,0 over 9 cycles starting 1 cycle after the handshake; last only on the 9th cycle; serial_valid low afterwards.
- Stall:
  - Stimulus: load 8'h3C, drop adv for 3 cycles after bit 2.
  - Response: bit 2 (=1) held stable for 4 cycles, cnt frozen, remaining sequence 1,1,1,0,0,0 unchanged; frame completes 3 cycles later than unstalled.
- Back-to-back:
  - Stimulus: load_valid held with 8'hA5 then 8'hFF presented at the final beat.
  - Response: load_ready high only on the last-bit cycle; second frame's bit0=1 follows the first frame's pad bit with no gap; 18 contiguous valid cycles.
- Ignored load:
  - Stimulus: load_valid=1 with data 8'h00 at cnt=4 of an 8'hA5 frame.
  - Response: load_ready=0 and the frame unaffected.
- Reset mid-frame:
  - Stimulus: assert rst at cnt=5.
  - Response: next cycle serial_valid=0, serial_out=0, load_ready=1 after rst deasserts; a fresh 8'h81 load emits 1,0,0,0,0,0,0,1,0.
- Loopback with serial capture register:
  - Stimulus: WIDTH=8 capture stage enabled by serial_valid & adv; send 8'hA5.
  - Response: captured 9-bit word = 9'h0A5. Also run PAD=0 and confirm 8 beats only.
